// File: rtl/fpu_pkg.sv
// Shared FP-exception types: sequencer state encoding and the 3-bit checker codes.
package fpu_pkg;

   typedef enum logic [1:0] {
      SeqIdle,
      SeqDrive,
      SeqRelease,
      SeqOutput
   } ExcSeqState;

   localparam logic [2:0] EXC_NONE = 3'b000;
   localparam logic [2:0] EXC_INF  = 3'b011;
   localparam logic [2:0] EXC_NAN  = 3'b100;
   localparam logic [2:0] EXC_TMO  = 3'b111;

endpackage

// File: rtl/fpu_exc_sequencer_if.sv
// Operand-in, checker handshake, result-out and status bundle of the exception sequencer.
interface fpu_exc_sequencer_if;

   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] chk_data;
   logic        chk_valid;
   logic        chk_ack;
   logic [2:0]  chk_aexc;
   logic [31:0] res_data;
   logic [2:0]  res_aexc;
   logic        res_valid;
   logic        res_ready;
   logic        sticky_inf;
   logic        sticky_nan;
   logic        clr_sticky;
   logic        timeout_err;

   modport master (
      input  in_data, in_valid, chk_ack, chk_aexc, res_ready, clr_sticky,
      output in_ready, chk_data, chk_valid, res_data, res_aexc, res_valid,
             sticky_inf, sticky_nan, timeout_err
   );

   modport slave (
      output in_data, in_valid, chk_ack, chk_aexc, res_ready, clr_sticky,
      input  in_ready, chk_data, chk_valid, res_data, res_aexc, res_valid,
             sticky_inf, sticky_nan, timeout_err
   );

endinterface

// File: rtl/fpu_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push and pop may coincide even when full.
module fpu_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty   = (wptr_q == rptr_q);
   assign head    = mem_q[rptr_q[AW-1:0]];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      mem_d  = mem_q;
      if (do_push) begin
         mem_d[wptr_q[AW-1:0]] = wdata;
         wptr_d                = wptr_q + 1'b1;
      end
      if (do_pop) rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: entries are only read between matching push/pop.
   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fpu_exc_sequencer.sv
// Feeds buffered FP operands to the exception checker one at a time and collects its codes.
//  state      | meaning
//  SeqIdle    | waiting for an operand in the FIFO
//  SeqDrive   | chk_valid high, waiting for chk_ack or timeout
//  SeqRelease | chk_valid low for two cycles so the checker can return to Compute
//  SeqOutput  | result presented downstream until accepted
module fpu_exc_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input logic                 CLK,
   input logic                 RSTN,
   fpu_exc_sequencer_if.master bus
);
   import fpu_pkg::*;

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   ExcSeqState    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [31:0]   chk_data_q, chk_data_d;
   logic          chk_valid_q, chk_valid_d;
   logic [31:0]   res_data_q, res_data_d;
   logic [2:0]    res_aexc_q, res_aexc_d;
   logic          sticky_inf_q, sticky_inf_d;
   logic          sticky_nan_q, sticky_nan_d;
   logic          timeout_err_q, timeout_err_d;
   logic          live_q;

   logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [31:0]   fifo_head;
   logic          load, capture, abort;

   assign fifo_push = bus.in_valid && bus.in_ready;

   fpu_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (bus.in_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q <= SeqIdle;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      fifo_pop = 1'b0;
      load     = 1'b0;
      capture  = 1'b0;
      abort    = 1'b0;
      unique case (state_q)
         SeqIdle: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               load     = 1'b1;
               timer_d  = '0;
               state_d  = SeqDrive;
            end
         end
         SeqDrive: begin
            timer_d = timer_q + 1'b1;
            if (bus.chk_ack) begin
               capture = 1'b1;
               timer_d = '0;
               state_d = SeqRelease;
            end else if (timer_q == TMO_LAST) begin
               abort   = 1'b1;
               timer_d = '0;
               state_d = SeqRelease;
            end
         end
         SeqRelease: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == TW'(1)) begin
               timer_d = '0;
               state_d = SeqOutput;
            end
         end
         SeqOutput: begin
            if (bus.res_ready) begin
               timer_d = '0;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  load     = 1'b1;
                  state_d  = SeqDrive;
               end else begin
                  state_d = SeqIdle;
               end
            end
         end
         default: state_d = SeqIdle;
      endcase
   end

   // A sticky set in the capture cycle overrides a simultaneous clear.
   always_comb begin
      chk_valid_d   = load ? 1'b1 : ((capture || abort) ? 1'b0 : chk_valid_q);
      chk_data_d    = load ? fifo_head : chk_data_q;
      res_data_d    = (capture || abort) ? chk_data_q : res_data_q;
      res_aexc_d    = capture ? bus.chk_aexc : (abort ? EXC_TMO : res_aexc_q);
      timeout_err_d = abort;
      sticky_inf_d  = (capture && (bus.chk_aexc == EXC_INF)) || (sticky_inf_q && !bus.clr_sticky);
      sticky_nan_d  = (capture && (bus.chk_aexc == EXC_NAN)) || (sticky_nan_q && !bus.clr_sticky);
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         chk_data_q    <= '0;
         chk_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_aexc_q    <= EXC_NONE;
         sticky_inf_q  <= 1'b0;
         sticky_nan_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         live_q        <= 1'b0;
      end else begin
         chk_data_q    <= chk_data_d;
         chk_valid_q   <= chk_valid_d;
         res_data_q    <= res_data_d;
         res_aexc_q    <= res_aexc_d;
         sticky_inf_q  <= sticky_inf_d;
         sticky_nan_q  <= sticky_nan_d;
         timeout_err_q <= timeout_err_d;
         live_q        <= 1'b1;
      end
   end

   always_comb begin
      bus.in_ready    = live_q && !fifo_full;
      bus.chk_data    = chk_data_q;
      bus.chk_valid   = chk_valid_q;
      bus.res_data    = res_data_q;
      bus.res_aexc    = res_aexc_q;
      bus.res_valid   = (state_q == SeqOutput);
      bus.sticky_inf  = sticky_inf_q;
      bus.sticky_nan  = sticky_nan_q;
      bus.timeout_err = timeout_err_q;
   end

endmodule

// File: tb/tb_fpu_exc_sequencer.sv
// Directed bench for fpu_exc_sequencer with a behavioural checker that can be muted to force timeouts.
module tb_fpu_exc_sequencer;

   logic CLK  = 1'b0;
   logic RSTN = 1'b0;
   bit   chk_stub = 1'b0;
   int   checks = 0;
   int   errors = 0;

   fpu_exc_sequencer_if bus ();

   fpu_exc_sequencer #(.DEPTH(4), .TIMEOUT(64)) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   function automatic logic [2:0] classify(input logic [31:0] f);
      if (f[30:23] == 8'hFF) return (f[22:0] == 23'd0) ? 3'b011 : 3'b100;
      return 3'b000;
   endfunction

   // Checker model: acks on the second cycle of chk_valid; code is garbage outside the ack cycle.
   initial begin
      int cnt;
      cnt = 0;
      bus.chk_ack  = 1'b0;
      bus.chk_aexc = 3'b101;
      forever begin
         @(posedge CLK); #2;
         bus.chk_ack  = 1'b0;
         bus.chk_aexc = 3'b101;
         if (!bus.chk_valid) cnt = 0;
         else begin
            cnt++;
            if (cnt == 2 && !chk_stub) begin
               bus.chk_ack  = 1'b1;
               bus.chk_aexc = classify(bus.chk_data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic push(input logic [31:0] d, output bit ok);
      ok = 1'b0;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         ok = bus.in_ready;
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_res(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (bus.res_valid) ok = 1'b1;
         else tick();
      end
   endtask

   task automatic consume();
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
   endtask

   task automatic test_reset();
      RSTN = 1'b0;
      repeat (3) tick();
      checks++;
      if ({bus.in_ready, bus.chk_valid, bus.res_valid, bus.sticky_inf, bus.sticky_nan, bus.timeout_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b cv=%b rv=%b si=%b sn=%b te=%b want all 0",
                  bus.in_ready, bus.chk_valid, bus.res_valid, bus.sticky_inf, bus.sticky_nan, bus.timeout_err);
      end
      checks++;
      if (bus.res_aexc !== 3'b000 || bus.chk_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got aexc=%b chk_data=%h want 000/0", bus.res_aexc, bus.chk_data);
      end
      RSTN = 1'b1;
      tick();
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_inf();
      bit ok;
      push(32'h7F800000, ok);
      checks++;
      if (!ok || bus.chk_valid !== 1'b0) begin
         errors++;
         $display("FAIL inf_accept got ok=%b chk_valid=%b want 1/0", ok, bus.chk_valid);
      end
      tick();
      checks++;
      if (bus.chk_valid !== 1'b1 || bus.chk_data !== 32'h7F800000) begin
         errors++;
         $display("FAIL inf_latency got cv=%b data=%h want 1/7f800000", bus.chk_valid, bus.chk_data);
      end
      wait_res(ok);
      checks++;
      if (!ok || bus.res_aexc !== 3'b011 || bus.res_data !== 32'h7F800000) begin
         errors++;
         $display("FAIL inf_result got ok=%b aexc=%b data=%h want 1/011/7f800000", ok, bus.res_aexc, bus.res_data);
      end
      checks++;
      if (bus.sticky_inf !== 1'b1 || bus.sticky_nan !== 1'b0) begin
         errors++;
         $display("FAIL inf_sticky got inf=%b nan=%b want 1/0", bus.sticky_inf, bus.sticky_nan);
      end
      consume();
   endtask

   task automatic test_nan_normal();
      bit ok0, ok1, seenhi;
      int nres, low, gap;
      logic [34:0] r [2];
      push(32'h7FC00000, ok0);
      push(32'h3F800000, ok1);
      bus.res_ready = 1'b1;
      nres = 0; low = 0; gap = -1; seenhi = 1'b0;
      for (int i = 0; i < 300 && nres < 2; i++) begin
         if (bus.chk_valid) begin
            if (seenhi && low > 0 && gap < 0) gap = low;
            seenhi = 1'b1;
            low    = 0;
         end else if (seenhi) low++;
         if (bus.res_valid) begin
            r[nres] = {bus.res_data, bus.res_aexc};
            nres++;
         end
         tick();
      end
      bus.res_ready = 1'b0;
      checks++;
      if (!ok0 || !ok1 || nres != 2) begin
         errors++;
         $display("FAIL nan_count got pushes=%b%b results=%0d want 11/2", ok0, ok1, nres);
      end
      checks++;
      if (r[0] !== {32'h7FC00000, 3'b100} || r[1] !== {32'h3F800000, 3'b000}) begin
         errors++;
         $display("FAIL nan_order got %h/%b %h/%b want 7fc00000/100 3f800000/000",
                  r[0][34:3], r[0][2:0], r[1][34:3], r[1][2:0]);
      end
      checks++;
      if (gap < 2) begin
         errors++;
         $display("FAIL nan_gap got %0d low cycles want >=2", gap);
      end
      checks++;
      if (bus.sticky_nan !== 1'b1 || bus.sticky_inf !== 1'b1) begin
         errors++;
         $display("FAIL nan_sticky got inf=%b nan=%b want 1/1", bus.sticky_inf, bus.sticky_nan);
      end
   endtask

   task automatic test_fill();
      logic [31:0] ops [5];
      logic [2:0]  codes [5];
      logic [34:0] got [5];
      int nacc, nres;
      bit ok;
      ops   = '{32'h00000000, 32'hFF800000, 32'h7FC00001, 32'h40490FDB, 32'hFFFFFFFF};
      codes = '{3'b000, 3'b011, 3'b100, 3'b000, 3'b100};
      nacc  = 0;
      foreach (ops[i]) begin
         push(ops[i], ok);
         if (ok) nacc++;
      end
      checks++;
      if (nacc != 5 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_full got accepts=%0d in_ready=%b want 5/0", nacc, bus.in_ready);
      end
      repeat (5) tick();
      checks++;
      if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_data !== 32'h0) begin
         errors++;
         $display("FAIL fill_hold got rdy=%b rv=%b data=%h want 0/1/0", bus.in_ready, bus.res_valid, bus.res_data);
      end
      bus.res_ready = 1'b1;
      nres = 0;
      for (int i = 0; i < 500 && nres < 5; i++) begin
         if (bus.res_valid) begin
            got[nres] = {bus.res_data, bus.res_aexc};
            nres++;
         end
         tick();
      end
      bus.res_ready = 1'b0;
      checks++;
      if (nres != 5) begin
         errors++;
         $display("FAIL fill_count got %0d results want 5", nres);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (got[i] !== {ops[i], codes[i]}) begin
            errors++;
            $display("FAIL fill_result%0d got %h/%b want %h/%b", i, got[i][34:3], got[i][2:0], ops[i], codes[i]);
         end
      end
   endtask

   task automatic test_sticky_clr();
      bit ok;
      push(32'h7F800000, ok);
      tick();
      checks++;
      if (!ok || bus.chk_valid !== 1'b1) begin
         errors++;
         $display("FAIL clr_setup got ok=%b chk_valid=%b want 1/1", ok, bus.chk_valid);
      end
      tick();
      bus.clr_sticky = 1'b1;
      tick();
      checks++;
      if (bus.sticky_inf !== 1'b1 || bus.sticky_nan !== 1'b0) begin
         errors++;
         $display("FAIL clr_set_wins got inf=%b nan=%b want 1/0", bus.sticky_inf, bus.sticky_nan);
      end
      tick();
      bus.clr_sticky = 1'b0;
      checks++;
      if (bus.sticky_inf !== 1'b0 || bus.sticky_nan !== 1'b0) begin
         errors++;
         $display("FAIL clr_alone got inf=%b nan=%b want 0/0", bus.sticky_inf, bus.sticky_nan);
      end
      wait_res(ok);
      checks++;
      if (!ok || bus.res_aexc !== 3'b011) begin
         errors++;
         $display("FAIL clr_result got ok=%b aexc=%b want 1/011", ok, bus.res_aexc);
      end
      consume();
   endtask

   task automatic test_timeout();
      bit ok;
      int hi, te;
      chk_stub = 1'b1;
      push(32'h7F800000, ok);
      hi = 0; te = 0; ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (bus.chk_valid) hi++;
         if (bus.timeout_err) te++;
         if (bus.res_valid) ok = 1'b1;
         else tick();
      end
      checks++;
      if (!ok || hi != 64 || te != 1) begin
         errors++;
         $display("FAIL tmo_timing got done=%b drive=%0d pulses=%0d want 1/64/1", ok, hi, te);
      end
      checks++;
      if (bus.res_aexc !== 3'b111 || bus.res_data !== 32'h7F800000) begin
         errors++;
         $display("FAIL tmo_result got aexc=%b data=%h want 111/7f800000", bus.res_aexc, bus.res_data);
      end
      checks++;
      if (bus.sticky_inf !== 1'b0 || bus.sticky_nan !== 1'b0) begin
         errors++;
         $display("FAIL tmo_sticky got inf=%b nan=%b want 0/0", bus.sticky_inf, bus.sticky_nan);
      end
      consume();
      chk_stub = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok0, ok1, ok2, ok;
      int hi;
      chk_stub = 1'b1;
      push(32'h7F800000, ok0);
      push(32'h7FC00000, ok1);
      push(32'h3F800000, ok2);
      checks++;
      if (!(ok0 && ok1 && ok2) || bus.chk_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_setup got pushes=%b%b%b chk_valid=%b want 111/1", ok0, ok1, ok2, bus.chk_valid);
      end
      RSTN = 1'b0;
      tick();
      checks++;
      if (bus.chk_valid !== 1'b0 || bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got cv=%b rv=%b rdy=%b want 0/0/0", bus.chk_valid, bus.res_valid, bus.in_ready);
      end
      RSTN = 1'b1;
      chk_stub = 1'b0;
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.chk_valid || bus.res_valid) hi++;
      end
      checks++;
      if (hi != 0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_flush got busy_cycles=%0d rdy=%b want 0/1", hi, bus.in_ready);
      end
      push(32'hFF800000, ok0);
      wait_res(ok);
      checks++;
      if (!ok0 || !ok || bus.res_aexc !== 3'b011 || bus.res_data !== 32'hFF800000) begin
         errors++;
         $display("FAIL rst_post got ok=%b aexc=%b data=%h want 1/011/ff800000", ok, bus.res_aexc, bus.res_data);
      end
      consume();
   endtask

   initial begin
      bus.in_data    = '0;
      bus.in_valid   = 1'b0;
      bus.res_ready  = 1'b0;
      bus.clr_sticky = 1'b0;
      test_reset();
      test_inf();
      test_nan_normal();
      test_fill();
      test_sticky_clr();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
